// File: rtl/ctrl_pipe_chain.sv
// Control-bundle pipeline chain: DEPTH register stages with valid, stall, flush and bubble insertion.
// Define CTRL_PIPE_PERF_EN to add the bubble_cnt / stall_cnt performance counters.
module ctrl_pipe_chain #(
    parameter int              WIDTH  = 4,
    parameter int              DEPTH  = 2,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       ctrl_in,
    input  logic                   valid_in,
    input  logic [DEPTH-1:0]       stall,
    input  logic [DEPTH-1:0]       flush,
    output logic                   ready_in,
    output logic [DEPTH*WIDTH-1:0] ctrl_tap,
    output logic [DEPTH-1:0]       valid_tap,
    output logic [WIDTH-1:0]       ctrl_out,
    output logic                   valid_out
`ifdef CTRL_PIPE_PERF_EN
    ,
    output logic [15:0]            bubble_cnt,
    output logic [15:0]            stall_cnt
`endif
);

    logic [DEPTH-1:0][WIDTH-1:0] ctrl_q, ctrl_d;
    logic [DEPTH-1:0]            valid_q, valid_d;
    logic [DEPTH-1:0]            hold;

    // A stall freezes its own stage and every stage upstream of it.
    for (genvar g = 0; g < DEPTH; g++) begin : g_hold
        assign hold[g] = |stall[DEPTH-1:g];
    end

    assign ready_in = ~hold[0];

    always_comb begin
        ctrl_d  = ctrl_q;
        valid_d = valid_q;

        if (flush[0]) begin
            valid_d[0] = 1'b0;
            ctrl_d[0]  = BUBBLE;
        end else if (!hold[0]) begin
            valid_d[0] = valid_in;
            ctrl_d[0]  = valid_in ? ctrl_in : BUBBLE;
        end

        // A draining stage behind a held neighbour receives a bubble.
        for (int i = 1; i < DEPTH; i++) begin
            if (flush[i]) begin
                valid_d[i] = 1'b0;
                ctrl_d[i]  = BUBBLE;
            end else if (!hold[i]) begin
                if (hold[i-1]) begin
                    valid_d[i] = 1'b0;
                    ctrl_d[i]  = BUBBLE;
                end else begin
                    valid_d[i] = valid_q[i-1];
                    ctrl_d[i]  = ctrl_q[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ctrl_q[i] <= BUBBLE;
            end
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign ctrl_tap  = ctrl_q;
    assign valid_tap = valid_q;
    assign ctrl_out  = ctrl_q[DEPTH-1];
    assign valid_out = valid_q[DEPTH-1];

`ifdef CTRL_PIPE_PERF_EN
    logic [15:0] bubble_cnt_q, stall_cnt_q;

    // Both counters saturate rather than wrap.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bubble_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            if (!valid_q[DEPTH-1] && bubble_cnt_q != 16'hFFFF) begin
                bubble_cnt_q <= bubble_cnt_q + 16'd1;
            end
            if (hold[0] && stall_cnt_q != 16'hFFFF) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign stall_cnt  = stall_cnt_q;
`endif

endmodule
